// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage controller.
// Owns the program counter and the IF/ID pipeline register. Each rising edge
// applies, in fixed priority, reset, exception vectoring, branch/jump redirect,
// hazard hold and flush requests. The instruction memory is read
// combinationally at imem_addr == pc. A saturating counter records how many
// edges loaded IF/ID with a bubble.
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             if_flush,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             exc_req,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc_plus4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Tracks what the most recent edge did to the front end. It has no port;
  // it exists so the pipeline invariant below can be stated.
  typedef enum logic [1:0] {
    RUN,
    HELD,
    REDIRECTED
  } track_t;

  track_t track;

  logic [31:0] pc_plus4;
  logic        bubble_load;
  logic        cnt_full;

  // The fetch address is the PC itself; the memory adds no latency.
  assign imem_addr = pc;

  // 32-bit modulo addition: 32'hFFFF_FFFC + 4 wraps to 0.
  assign pc_plus4 = pc + 32'd4;

  // Any exception, redirect or flush (with or without hold) replaces the
  // IF/ID contents with a bubble. Hold alone leaves IF/ID untouched.
  assign bubble_load = exc_req | redirect_valid | if_flush;

  assign cnt_full = &bubble_cnt;

  // Program counter and tracker: exception beats redirect, redirect beats hold.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so all state
    // updates on this edge see the pre-edge values of pc and the inputs.
    if (reset) begin
      pc    <= RESET_PC;
      track <= RUN;
    end else if (exc_req) begin
      pc    <= EXC_VECTOR;
      track <= REDIRECTED;
    end else if (redirect_valid) begin
      pc    <= redirect_target;
      track <= REDIRECTED;
    end else if (hold) begin
      pc    <= pc;
      track <= HELD;
    end else begin
      pc    <= pc_plus4;
      track <= RUN;
    end
  end

  // IF/ID register: bubble on redirect/exception/flush, capture when running,
  // unchanged when only held. A bubble keeps pc+4 for exception return.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else if (bubble_load) begin
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= pc_plus4;
      ifid_valid    <= 1'b0;
    end else if (!hold) begin
      ifid_instr    <= imem_rdata;
      ifid_pc_plus4 <= pc_plus4;
      ifid_valid    <= 1'b1;
    end
  end

  // Saturating bubble counter: one count per bubble-loading edge, stops at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (bubble_load && !cnt_full) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifndef SYNTHESIS
  // The edge that enters REDIRECTED also loads a bubble, so the stage handed
  // to decode in that cycle must never be marked valid.
  a_no_valid_after_redirect : assert property (
    @(posedge clk) disable iff (reset) (track == REDIRECTED) |-> !ifid_valid
  );
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed testbench for if_stage_ctrl. A table of per-edge vectors with
// hand-computed expected values walks the main sequence; hand-written
// sequences then cover counter saturation and exception-over-hold. A second
// instance with a 4-bit counter shares the stimulus to show saturation.
module tb_if_stage_ctrl;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        if_flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_req;
  logic [31:0] imem_rdata;

  logic [31:0] imem_addr, pc, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid;
  logic [15:0] bubble_cnt;

  logic [31:0] s_imem_addr, s_pc, s_ifid_instr, s_ifid_pc_plus4;
  logic        s_ifid_valid;
  logic [3:0]  s_bubble_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  if_stage_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .hold            (hold),
    .if_flush        (if_flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .imem_rdata      (imem_rdata),
    .imem_addr       (imem_addr),
    .pc              (pc),
    .ifid_instr      (ifid_instr),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .bubble_cnt      (bubble_cnt)
  );

  if_stage_ctrl #(.CNT_W(4)) dut_s (
    .clk             (clk),
    .reset           (reset),
    .hold            (hold),
    .if_flush        (if_flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .imem_rdata      (imem_rdata),
    .imem_addr       (s_imem_addr),
    .pc              (s_pc),
    .ifid_instr      (s_ifid_instr),
    .ifid_pc_plus4   (s_ifid_pc_plus4),
    .ifid_valid      (s_ifid_valid),
    .bubble_cnt      (s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hld;
    logic        fl;
    logic        rv;
    logic [31:0] rt;
    logic        exc;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic rst, input logic hld, input logic fl, input logic rv,
                       input logic [31:0] rt, input logic exc, input logic [31:0] rdata);
    reset           = rst;
    hold            = hld;
    if_flush        = fl;
    redirect_valid  = rv;
    redirect_target = rt;
    exc_req         = exc;
    imem_rdata      = rdata;
  endtask

  // Drive, take one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                rst hld fl rv  rt            exc rdata          e_pc          e_instr        e_pp4         v  cnt
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,        32'h8000_0000,32'h0,        32'h0,        1'b0,16'd0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h2008_0005,32'h8000_0004,32'h2008_0005,32'h8000_0004,1'b1,16'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h1111_1111,32'h8000_0008,32'h1111_1111,32'h8000_0008,1'b1,16'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h2222_2222,32'h8000_000C,32'h2222_2222,32'h8000_000C,1'b1,16'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h3333_3333,32'h8000_0010,32'h3333_3333,32'h8000_0010,1'b1,16'd0};
    // hold alone for three edges: nothing moves
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,32'h4444_4444,32'h8000_0010,32'h3333_3333,32'h8000_0010,1'b1,16'd0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,32'h4444_4444,32'h8000_0010,32'h3333_3333,32'h8000_0010,1'b1,16'd0};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,32'h4444_4444,32'h8000_0010,32'h3333_3333,32'h8000_0010,1'b1,16'd0};
    // hold + flush: PC held, bubble inserted
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,       1'b0,32'h4444_4444,32'h8000_0010,32'h0,        32'h8000_0014,1'b0,16'd1};
    // refetch of 0x80000010
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h4444_4444,32'h8000_0014,32'h4444_4444,32'h8000_0014,1'b1,16'd1};
    // redirect overrides hold
    vecs[10] = '{1'b0,1'b1,1'b0,1'b1,32'h8000_0100,1'b0,32'h5555_0000,32'h8000_0100,32'h0,        32'h8000_0018,1'b0,16'd2};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h5555_5555,32'h8000_0104,32'h5555_5555,32'h8000_0104,1'b1,16'd2};
    // flush alone: PC advances, bubble inserted
    vecs[12] = '{1'b0,1'b0,1'b1,1'b0,32'h0,       1'b0,32'h6666_6666,32'h8000_0108,32'h0,        32'h8000_0108,1'b0,16'd3};
    // exception beats redirect
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,32'h8000_0200,1'b1,32'h7777_0000,32'h8000_0008,32'h0,        32'h8000_010C,1'b0,16'd4};
    // reset beats redirect
    vecs[14] = '{1'b1,1'b0,1'b0,1'b1,32'h8000_0300,1'b0,32'h7777_0001,32'h8000_0000,32'h0,        32'h0,        1'b0,16'd0};
    // redirect to top of address space, then wrap to 0
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h7777_0002,32'hFFFF_FFFC,32'h0,        32'h8000_0004,1'b0,16'd1};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h7777_7777,32'h0000_0000,32'h7777_7777,32'h0000_0000,1'b1,16'd1};
    // unaligned target passes through unchanged
    vecs[17] = '{1'b0,1'b0,1'b0,1'b1,32'h0000_0123,1'b0,32'h8888_0000,32'h0000_0123,32'h0,        32'h0000_0004,1'b0,16'd2};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h8888_8888,32'h0000_0127,32'h8888_8888,32'h0000_0127,1'b1,16'd2};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].hld, vecs[i].fl, vecs[i].rv, vecs[i].rt, vecs[i].exc, vecs[i].rdata);
      step();
      check($sformatf("v%0d pc", i),        pc,                    vecs[i].e_pc);
      check($sformatf("v%0d imem_addr", i), imem_addr,             vecs[i].e_pc);
      check($sformatf("v%0d instr", i),     ifid_instr,            vecs[i].e_instr);
      check($sformatf("v%0d pc_plus4", i),  ifid_pc_plus4,         vecs[i].e_pp4);
      check($sformatf("v%0d valid", i),     {31'd0, ifid_valid},   {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d cnt", i),       {16'd0, bubble_cnt},   {16'd0, vecs[i].e_cnt});
      check($sformatf("v%0d cnt4", i),      {28'd0, s_bubble_cnt}, {16'd0, vecs[i].e_cnt});
    end

    // Saturation: reset, then 20 flush-only edges.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("sat reset cnt4", {28'd0, s_bubble_cnt}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEAD_0000 + 32'(i));
      step();
      check($sformatf("sat%0d cnt4", i), {28'd0, s_bubble_cnt}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      check($sformatf("sat%0d valid", i), {31'd0, ifid_valid}, 32'd0);
    end
    check("sat cnt16", {16'd0, bubble_cnt}, 32'd20);
    check("sat pc",    pc,                  32'h8000_0050);
    check("sat instr", ifid_instr,          32'h0);

    // Exception beats hold; saturated counter stays put, wide one advances.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBEEF_0000);
    step();
    check("exc_hold pc",    pc,                    32'h8000_0008);
    check("exc_hold pp4",   ifid_pc_plus4,         32'h8000_0054);
    check("exc_hold cnt16", {16'd0, bubble_cnt},   32'd21);
    check("exc_hold cnt4",  {28'd0, s_bubble_cnt}, 32'd15);

    // Hold-only from the exception vector: counters do not move.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hBEEF_0001);
    step();
    check("hold pc",    pc,                  32'h8000_0008);
    check("hold valid", {31'd0, ifid_valid}, 32'd0);
    check("hold cnt16", {16'd0, bubble_cnt}, 32'd21);

    // Release: fetch at the exception vector.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hCAFE_F00D);
    step();
    check("vec pc",    pc,                  32'h8000_000C);
    check("vec instr", ifid_instr,          32'hCAFE_F00D);
    check("vec pp4",   ifid_pc_plus4,       32'h8000_000C);
    check("vec valid", {31'd0, ifid_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
